// File: rtl/ms_event_pkg.sv
// Shared types and constants for the millisecond event timestamper.
// Latency: n/a (types only).
// Backpressure: n/a.
package ms_event_pkg;

    localparam int TS_W    = 32;
    localparam int SEQ_W   = 16;
    localparam int CODE_W  = 8;
    localparam int ENTRY_W = TS_W + SEQ_W + CODE_W;
    localparam int DROP_W  = 16;

    // Beat1 layout: {seq, 8'h00, event_code}
    localparam int B1_CODE_LSB = 0;
    localparam int B1_PAD_LSB  = 8;
    localparam int B1_SEQ_LSB  = 16;

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1
    } state_t;

    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [SEQ_W-1:0]  seq;
        logic [CODE_W-1:0] code;
    } entry_t;

    function automatic logic [31:0] make_beat1(input logic [SEQ_W-1:0] seq,
                                               input logic [CODE_W-1:0] code);
        logic [31:0] b;
        b = '0;
        b[B1_SEQ_LSB +: SEQ_W]   = seq;
        b[B1_PAD_LSB +: 8]       = 8'h00;
        b[B1_CODE_LSB +: CODE_W] = code;
        return b;
    endfunction

endpackage

// File: rtl/ms_event_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head (rd_dat).
// Latency: a write is visible on rd_dat/!empty the cycle after it is taken.
// Backpressure: writes while full and reads while empty are ignored.
module ms_event_fifo #(
    parameter int WIDTH = 56,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_nxt;
    logic             wr_en;
    logic             rd_en;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en  = wr_vld & ~full;
    assign rd_en  = rd_rdy & ~empty;
    assign rd_nxt = rd_ptr + {{AW{1'b0}}, rd_en};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rd_dat <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_nxt;
            // The new head is either the word being written now or one already in memory.
            if (wr_en && (wr_ptr == rd_nxt))
                rd_dat <= wr_dat;
            else
                rd_dat <= mem[rd_nxt[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end

endmodule

// File: rtl/ms_event_timestamper.sv
// Stamps event strobes with the latest millisecond count and emits each as a 2-beat AXIS packet.
// Latency: event in cycle N -> beat0 valid in cycle N+2 with an idle output; 1 beat/cycle sustained.
// Backpressure: never stalls the counter stream; events arriving with a full queue are dropped and counted.
module ms_event_timestamper
    import ms_event_pkg::*;
#(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH             = 8
) (
    input  logic                                s00_axis_aclk,
    input  logic                                s00_axis_aresetn,
    input  logic                                s00_axis_tvalid,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                                s00_axis_tlast,
    output logic                                s00_axis_tready,
    input  logic                                event_valid,
    input  logic [CODE_W-1:0]                   event_code,
    output logic                                m00_axis_tvalid,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                                m00_axis_tlast,
    input  logic                                m00_axis_tready,
    output logic [DROP_W-1:0]                   drop_count
);

    logic                 unused_inputs;
    logic                 s_hs;
    logic                 m_hs;
    logic [TS_W-1:0]      current_ms;
    logic                 ms_seen;
    logic [SEQ_W-1:0]     seq;
    logic [TS_W-1:0]      ev_ts;
    logic                 push;
    logic                 drop;
    entry_t               wr_entry;
    entry_t               head;
    logic [ENTRY_W-1:0]   fifo_rd_dat;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;

    state_t               state, state_nxt;
    logic                 tvalid_nxt;
    logic [31:0]          tdata_nxt;
    logic                 tlast_nxt;
    logic [SEQ_W-1:0]     hold_seq, hold_seq_nxt;
    logic [CODE_W-1:0]    hold_code, hold_code_nxt;

    assign unused_inputs  = ^{s00_axis_tstrb, s00_axis_tlast};
    assign m00_axis_tstrb = '1;
    assign s_hs           = s00_axis_tvalid & s00_axis_tready;
    assign m_hs           = m00_axis_tvalid & m00_axis_tready;

    // A same-cycle count handshake both supplies the timestamp and satisfies ms_seen.
    assign ev_ts    = s_hs ? s00_axis_tdata : current_ms;
    assign push     = event_valid & (ms_seen | s_hs) & ~fifo_full;
    assign drop     = event_valid & ~push;
    assign wr_entry = '{ts: ev_ts, seq: seq, code: event_code};
    assign head     = entry_t'(fifo_rd_dat);

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            s00_axis_tready <= 1'b0;
            current_ms      <= '0;
            ms_seen         <= 1'b0;
            seq             <= '0;
            drop_count      <= '0;
        end else begin
            s00_axis_tready <= 1'b1;
            if (s_hs) begin
                current_ms <= s00_axis_tdata;
                ms_seen    <= 1'b1;
            end
            if (push) seq <= seq + 1'b1;
            if (drop && (drop_count != '1)) drop_count <= drop_count + 1'b1;
        end
    end

    ms_event_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (s00_axis_aclk),
        .rst_n  (s00_axis_aresetn),
        .wr_vld (push),
        .wr_dat (wr_entry),
        .rd_rdy (pop),
        .rd_dat (fifo_rd_dat),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        state_nxt     = state;
        pop           = 1'b0;
        tvalid_nxt    = m00_axis_tvalid;
        tdata_nxt     = m00_axis_tdata;
        tlast_nxt     = m00_axis_tlast;
        hold_seq_nxt  = hold_seq;
        hold_code_nxt = hold_code;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop           = 1'b1;
                    tvalid_nxt    = 1'b1;
                    tdata_nxt     = head.ts;
                    tlast_nxt     = 1'b0;
                    hold_seq_nxt  = head.seq;
                    hold_code_nxt = head.code;
                    state_nxt     = BEAT0;
                end
            end
            BEAT0: begin
                if (m_hs) begin
                    tdata_nxt = make_beat1(hold_seq, hold_code);
                    tlast_nxt = 1'b1;
                    state_nxt = BEAT1;
                end
            end
            BEAT1: begin
                if (m_hs) begin
                    if (!fifo_empty) begin
                        pop           = 1'b1;
                        tdata_nxt     = head.ts;
                        tlast_nxt     = 1'b0;
                        hold_seq_nxt  = head.seq;
                        hold_code_nxt = head.code;
                        state_nxt     = BEAT0;
                    end else begin
                        tvalid_nxt = 1'b0;
                        state_nxt  = IDLE;
                    end
                end
            end
            default: begin
                tvalid_nxt = 1'b0;
                state_nxt  = IDLE;
            end
        endcase
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state           <= IDLE;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tdata  <= '0;
            m00_axis_tlast  <= 1'b0;
            hold_seq        <= '0;
            hold_code       <= '0;
        end else begin
            state           <= state_nxt;
            m00_axis_tvalid <= tvalid_nxt;
            m00_axis_tdata  <= tdata_nxt;
            m00_axis_tlast  <= tlast_nxt;
            hold_seq        <= hold_seq_nxt;
            hold_code       <= hold_code_nxt;
        end
    end

endmodule
